bus_ready_sequencer: RTL and testbench

//  Sequences CPU and DMA bus-cycle wait states for the XT chipset.
//  - Detects the start of each I/O or memory command.
//  - Inserts a programmable count of wait states, then holds until ISA I/O CHRDY is seen.
//  - Drives processor_ready (CPU cycles) and dma_ready (DMA cycles).
//  - Sits between the bus command decode and the 8284 RDY input / 8237 READY input.

---
 rtl/bus_ready_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_bus_ready_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_ready_sequencer.sv
// rtl/bus_ready_sequencer.sv - XT bus-cycle wait-state and ready sequencer for CPU and DMA cycles
// Define READY_TIMEOUT_EN to add the CHRDY watchdog and the bus_timeout pulse.
module bus_ready_sequencer #(
   parameter int IO_WAIT        = 1,
   parameter int MEM_WAIT       = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset,
   input  logic io_read_n,
   input  logic io_write_n,
   input  logic memory_read_n,
   input  logic memory_write_n,
   input  logic address_enable_n,
   input  logic dma0_acknowledge_n,
   input  logic io_channel_ready,
   input  logic dma_wait_n,
   output logic processor_ready,
   output logic dma_ready,
   output logic wait_active,
   output logic bus_timeout
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CNT = 2'd1,
      CHRDY    = 2'd2,
      DONE     = 2'd3
   } state_t;

   localparam logic [3:0] IO_WAIT_W  = 4'(IO_WAIT);
   localparam logic [3:0] MEM_WAIT_W = 4'(MEM_WAIT);

   if (IO_WAIT < 0 || IO_WAIT > 15) begin : g_bad_io_wait
      $error("IO_WAIT must be 0..15");
   end
   if (MEM_WAIT < 0 || MEM_WAIT > 15) begin : g_bad_mem_wait
      $error("MEM_WAIT must be 0..15");
   end
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 4095) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be 1..4095");
   end

   logic       chrdy_meta_q, chrdy_meta_d;
   logic       chrdy_s_q, chrdy_s_d;
   logic       cmd_q, cmd_d;
   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       processor_ready_q, processor_ready_d;
   logic       dma_ready_q, dma_ready_d;
   logic       wait_active_q, wait_active_d;
   logic       bus_timeout_q, bus_timeout_d;

   logic       cmd;
   logic       is_io;
   logic       start;
   logic       cpu_start;
   logic [3:0] wait_sel;
   logic       tmo_expired;

   always_comb begin
      cmd       = ~(io_read_n & io_write_n & memory_read_n & memory_write_n);
      is_io     = ~(io_read_n & io_write_n);
      start     = cmd & ~cmd_q;
      // Refresh (DACK0) and DMA (AEN low) cycles are invisible to the CPU sequencer.
      cpu_start = start & address_enable_n & dma0_acknowledge_n;
      wait_sel  = is_io ? IO_WAIT_W : MEM_WAIT_W;
   end

   always_comb begin
      chrdy_meta_d = io_channel_ready;
      chrdy_s_d    = chrdy_meta_q;
      cmd_d        = cmd;
      dma_ready_d  = ~(~address_enable_n & cmd & (~chrdy_s_q | ~dma_wait_n));
   end

`ifdef READY_TIMEOUT_EN
   localparam int              TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] tmo_q, tmo_d;

   // Held at zero outside CHRDY so every entry starts a fresh count.
   always_comb begin
      tmo_d = '0;
      if (state_q == CHRDY) begin
         tmo_d = tmo_q + TMO_W'(1);
      end
   end

   assign tmo_expired = (tmo_q == TMO_LAST);

   always_ff @(posedge clock) begin
      if (reset) begin
         tmo_q <= '0;
      end else begin
         tmo_q <= tmo_d;
      end
   end
`else
   assign tmo_expired = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bus_timeout_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu_start) begin
               if (wait_sel != 4'd0) begin
                  cnt_d   = wait_sel - 4'd1;
                  state_d = WAIT_CNT;
               end else if (!chrdy_s_q) begin
                  state_d = CHRDY;
               end else begin
                  state_d = DONE;
               end
            end
         end
         WAIT_CNT: begin
            if (!cmd) begin
               state_d = IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = CHRDY;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         CHRDY: begin
            if (!cmd) begin
               state_d = IDLE;
            end else if (chrdy_s_q) begin
               state_d = DONE;
            end else if (tmo_expired) begin
               state_d       = DONE;
               bus_timeout_d = 1'b1;
            end
         end
         DONE: begin
            // Stay here while the strobe is held so a lingering command cannot retrigger.
            if (!cmd) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      wait_active_d     = (state_d == WAIT_CNT) || (state_d == CHRDY);
      processor_ready_d = ~wait_active_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         chrdy_meta_q      <= 1'b1;
         chrdy_s_q         <= 1'b1;
         cmd_q             <= 1'b0;
         state_q           <= IDLE;
         cnt_q             <= 4'd0;
         processor_ready_q <= 1'b1;
         dma_ready_q       <= 1'b1;
         wait_active_q     <= 1'b0;
         bus_timeout_q     <= 1'b0;
      end else begin
         chrdy_meta_q      <= chrdy_meta_d;
         chrdy_s_q         <= chrdy_s_d;
         cmd_q             <= cmd_d;
         state_q           <= state_d;
         cnt_q             <= cnt_d;
         processor_ready_q <= processor_ready_d;
         dma_ready_q       <= dma_ready_d;
         wait_active_q     <= wait_active_d;
         bus_timeout_q     <= bus_timeout_d;
      end
   end

   assign processor_ready = processor_ready_q;
   assign dma_ready       = dma_ready_q;
   assign wait_active     = wait_active_q;
   assign bus_timeout     = bus_timeout_q;

endmodule

// File: tb/tb_bus_ready_sequencer.sv
// tb/tb_bus_ready_sequencer.sv - directed self-checking bench for bus_ready_sequencer
// Two instances share stimulus: A (IO_WAIT=1, MEM_WAIT=0) and B (IO_WAIT=4, MEM_WAIT=2).
module tb_bus_ready_sequencer;

   logic clock = 1'b0;
   logic reset;
   logic io_read_n, io_write_n, memory_read_n, memory_write_n;
   logic address_enable_n, dma0_acknowledge_n, io_channel_ready, dma_wait_n;
   logic ready_a, dma_ready_a, wait_a, tmo_a;
   logic ready_b, dma_ready_b, wait_b, tmo_b;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   bus_ready_sequencer #(.IO_WAIT(1), .MEM_WAIT(0), .TIMEOUT_CYCLES(16)) dut_a (
      .clock              (clock),
      .reset              (reset),
      .io_read_n          (io_read_n),
      .io_write_n         (io_write_n),
      .memory_read_n      (memory_read_n),
      .memory_write_n     (memory_write_n),
      .address_enable_n   (address_enable_n),
      .dma0_acknowledge_n (dma0_acknowledge_n),
      .io_channel_ready   (io_channel_ready),
      .dma_wait_n         (dma_wait_n),
      .processor_ready    (ready_a),
      .dma_ready          (dma_ready_a),
      .wait_active        (wait_a),
      .bus_timeout        (tmo_a)
   );

   bus_ready_sequencer #(.IO_WAIT(4), .MEM_WAIT(2), .TIMEOUT_CYCLES(16)) dut_b (
      .clock              (clock),
      .reset              (reset),
      .io_read_n          (io_read_n),
      .io_write_n         (io_write_n),
      .memory_read_n      (memory_read_n),
      .memory_write_n     (memory_write_n),
      .address_enable_n   (address_enable_n),
      .dma0_acknowledge_n (dma0_acknowledge_n),
      .io_channel_ready   (io_channel_ready),
      .dma_wait_n         (dma_wait_n),
      .processor_ready    (ready_b),
      .dma_ready          (dma_ready_b),
      .wait_active        (wait_b),
      .bus_timeout        (tmo_b)
   );

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_outs(input string tag,
                             input logic ra, input logic wa, input logic ta,
                             input logic rb, input logic wb, input logic tb,
                             input logic dr);
      check($sformatf("%s.ready_a", tag), 32'(ready_a), 32'(ra));
      check($sformatf("%s.wait_a", tag), 32'(wait_a), 32'(wa));
      check($sformatf("%s.tmo_a", tag), 32'(tmo_a), 32'(ta));
      check($sformatf("%s.ready_b", tag), 32'(ready_b), 32'(rb));
      check($sformatf("%s.wait_b", tag), 32'(wait_b), 32'(wb));
      check($sformatf("%s.tmo_b", tag), 32'(tmo_b), 32'(tb));
      check($sformatf("%s.dma_a", tag), 32'(dma_ready_a), 32'(dr));
      check($sformatf("%s.dma_b", tag), 32'(dma_ready_b), 32'(dr));
   endtask

   initial begin
      reset              = 1'b1;
      io_read_n          = 1'b1;
      io_write_n         = 1'b1;
      memory_read_n      = 1'b1;
      memory_write_n     = 1'b1;
      address_enable_n   = 1'b1;
      dma0_acknowledge_n = 1'b1;
      io_channel_ready   = 1'b1;
      dma_wait_n         = 1'b1;
      tick(3);
      check_outs("reset", 1, 0, 0, 1, 0, 0, 1);
      reset = 1'b0;
      tick(2);
      check_outs("idle", 1, 0, 0, 1, 0, 0, 1);

      // I/O read, CHRDY high: A low 2 clk; B aborted in WAIT_CNT when the strobe drops
      io_read_n = 1'b0;
      tick(1); check_outs("t1_e1", 0, 1, 0, 0, 1, 0, 1);
      tick(1); check_outs("t1_e2", 0, 1, 0, 0, 1, 0, 1);
      tick(1); check_outs("t1_e3", 1, 0, 0, 0, 1, 0, 1);
      io_read_n = 1'b1;
      tick(1); check_outs("t1_e4", 1, 0, 0, 1, 0, 0, 1);
      tick(2);

      // Memory read: A zero-wait, B two waits plus one CHRDY clock
      memory_read_n = 1'b0;
      tick(1); check_outs("t2_e1", 1, 0, 0, 0, 1, 0, 1);
      tick(1); check_outs("t2_e2", 1, 0, 0, 0, 1, 0, 1);
      tick(1); check_outs("t2_e3", 1, 0, 0, 0, 1, 0, 1);
      memory_read_n = 1'b1;
      tick(1); check_outs("t2_e4", 1, 0, 0, 1, 0, 0, 1);
      tick(2);

      // CHRDY low for 10 clk across an I/O write; release seen 3 edges after the rise
      io_channel_ready = 1'b0;
      tick(3);
      io_write_n = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         check_outs($sformatf("t3_k%0d", k), 0, 1, 0, 0, 1, 0, 1);
      end
      io_channel_ready = 1'b1;
      tick(1); check_outs("t3_r1", 0, 1, 0, 0, 1, 0, 1);
      tick(1); check_outs("t3_r2", 0, 1, 0, 0, 1, 0, 1);
      tick(1); check_outs("t3_r3", 1, 0, 0, 1, 0, 0, 1);
      io_write_n = 1'b1;
      tick(3);

      // CHRDY stuck low during an I/O read
      io_channel_ready = 1'b0;
      tick(3);
      io_read_n = 1'b0;
      for (int k = 1; k <= 22; k++) begin
         tick(1);
`ifdef READY_TIMEOUT_EN
         check_outs($sformatf("t4_k%0d", k),
                    k >= 18, k <= 17, k == 18,
                    k >= 21, k <= 20, k == 21, 1'b1);
`else
         check_outs($sformatf("t4_k%0d", k), 0, 1, 0, 0, 1, 0, 1);
`endif
      end
      io_read_n = 1'b1;
      tick(1); check_outs("t4_end", 1, 0, 0, 1, 0, 0, 1);
      io_channel_ready = 1'b1;
      tick(3);

      // DMA memory read stretched by dma_wait_n
      address_enable_n = 1'b0;
      memory_read_n    = 1'b0;
      dma_wait_n       = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick(1);
         check_outs($sformatf("t5_k%0d", k), 1, 0, 0, 1, 0, 0, 0);
      end
      address_enable_n = 1'b1;
      memory_read_n    = 1'b1;
      dma_wait_n       = 1'b1;
      tick(1); check_outs("t5_end", 1, 0, 0, 1, 0, 0, 1);
      tick(2);

      // DMA cycle stretched by CHRDY through the synchroniser
      address_enable_n = 1'b0;
      memory_write_n   = 1'b0;
      io_channel_ready = 1'b0;
      tick(1); check_outs("t5c_e1", 1, 0, 0, 1, 0, 0, 1);
      tick(1); check_outs("t5c_e2", 1, 0, 0, 1, 0, 0, 1);
      tick(1); check_outs("t5c_e3", 1, 0, 0, 1, 0, 0, 0);
      io_channel_ready = 1'b1;
      tick(1); check_outs("t5c_e4", 1, 0, 0, 1, 0, 0, 0);
      tick(1); check_outs("t5c_e5", 1, 0, 0, 1, 0, 0, 0);
      tick(1); check_outs("t5c_e6", 1, 0, 0, 1, 0, 0, 1);
      address_enable_n = 1'b1;
      memory_write_n   = 1'b1;
      tick(2);

      // Refresh cycle never moves the FSM
      dma0_acknowledge_n = 1'b0;
      memory_read_n      = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick(1);
         check_outs($sformatf("t5r_k%0d", k), 1, 0, 0, 1, 0, 0, 1);
      end
      dma0_acknowledge_n = 1'b1;
      memory_read_n      = 1'b1;
      tick(2);

      // AEN rises at the same edge as the strobe: treated as a CPU cycle
      address_enable_n = 1'b0;
      tick(2);
      address_enable_n = 1'b1;
      memory_read_n    = 1'b0;
      tick(1); check_outs("t5s_e1", 1, 0, 0, 0, 1, 0, 1);
      memory_read_n = 1'b1;
      tick(1); check_outs("t5s_e2", 1, 0, 0, 1, 0, 0, 1);
      tick(2);

      // Reset pulsed mid-cycle while A sits in CHRDY
      io_channel_ready = 1'b0;
      tick(3);
      io_read_n = 1'b0;
      tick(3); check_outs("t6_pre", 0, 1, 0, 0, 1, 0, 1);
      reset = 1'b1;
      tick(1); check_outs("t6_rst", 1, 0, 0, 1, 0, 0, 1);
      // Synchroniser restarts at 11, so A sees CHRDY high on the first cycle after reset
      reset         = 1'b0;
      io_read_n     = 1'b1;
      memory_read_n = 1'b0;
      tick(1); check_outs("t6_post", 1, 0, 0, 0, 1, 0, 1);
      memory_read_n    = 1'b1;
      io_channel_ready = 1'b1;
      tick(1); check_outs("t6_abort", 1, 0, 0, 1, 0, 0, 1);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
